// File: rtl/billiards_pkg.sv
// Shared billiards constants and types: ball position word layout,
// pocket marker and the motion-monitor state encoding.
`timescale 1ns/1ps
package billiards_pkg;

  localparam int NBALLS  = 16;
  localparam int POS_W   = 20;
  localparam int COORD_W = 10;
  localparam logic [COORD_W-1:0] POCKET_X = 10'h3FF;

  // One ball position word: X in the upper half, Y in the lower half.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } ball_pos_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EVAL = 2'd2
  } mon_state_t;

endpackage

// File: rtl/pos_delta_cmp.sv
// Per-axis motion compare between two ball positions. Flags movement when
// either axis changed by more than thresh pixels. Purely combinational so it
// can be shared with other per-ball logic.
`timescale 1ns/1ps
module pos_delta_cmp
  import billiards_pkg::*;
(
  input  ball_pos_t          cur,
  input  ball_pos_t          prev,
  input  logic [COORD_W-1:0] thresh,
  output logic               moved_raw
);

  logic signed [COORD_W:0] dx_s;
  logic signed [COORD_W:0] dy_s;
  logic [COORD_W:0]        dx;
  logic [COORD_W:0]        dy;

  // 11-bit signed differences cannot overflow for 10-bit unsigned operands,
  // and the magnitude of -1023 still fits after negation.
  always_comb begin
    dx_s      = $signed({1'b0, cur.x}) - $signed({1'b0, prev.x});
    dy_s      = $signed({1'b0, cur.y}) - $signed({1'b0, prev.y});
    dx        = dx_s[COORD_W] ? $unsigned(-dx_s) : $unsigned(dx_s);
    dy        = dy_s[COORD_W] ? $unsigned(-dy_s) : $unsigned(dy_s);
    moved_raw = (dx > {1'b0, thresh}) || (dy > {1'b0, thresh});
  end

endmodule

// File: rtl/ball_motion_monitor.sv
// Ball motion monitor: once per frame scans all ball positions, one ball per
// clock, against the positions seen last frame. Raises hw_sig after
// SETTLE_FRAMES consecutive frames in which no ball moved.
// frame_tick is a single-cycle pulse with no ready: a tick that lands while a
// scan is in flight is dropped and recorded in the sticky overrun flag.
`timescale 1ns/1ps
module ball_motion_monitor
  import billiards_pkg::*;
#(
  parameter int NBALLS        = billiards_pkg::NBALLS,
  parameter int THRESH        = 1,
  parameter int SETTLE_FRAMES = 8,
  parameter logic [9:0] POCKET_X = billiards_pkg::POCKET_X
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic                    frame_tick,
  input  logic                    clear,
  input  logic [NBALLS*POS_W-1:0] ball_pos,
  output logic                    hw_sig,
  output logic [NBALLS-1:0]       moving_mask,
  output logic [7:0]              still_cnt,
  output logic                    overrun,
  output mon_state_t              dbg_state
);

  localparam int IDX_W = $clog2(NBALLS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBALLS - 1);
  localparam logic [7:0] SETTLE = 8'(SETTLE_FRAMES);

  mon_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [NBALLS-1:0] scratch;
  logic             primed;
  ball_pos_t        prev_pos [NBALLS];

  ball_pos_t        cur;
  ball_pos_t        prev_cur;
  logic             moved_raw;
  logic             moved;
  logic [7:0]       next_cnt;

  // Select the ball under scan; positions are stable between frames, so the
  // live input is read directly without a snapshot.
  always_comb begin
    cur      = ball_pos[idx*POS_W +: POS_W];
    prev_cur = prev_pos[idx];
  end

  pos_delta_cmp u_cmp (
    .cur       (cur),
    .prev      (prev_cur),
    .thresh    (COORD_W'(THRESH)),
    .moved_raw (moved_raw)
  );

  // Pocketed balls are always still; before the first full scan the stored
  // positions are meaningless, so every on-table ball counts as moving.
  always_comb begin
    moved = (cur.x != POCKET_X) && (!primed || moved_raw);
  end

  // Still-frame counter for the frame being evaluated, saturating.
  always_comb begin
    next_cnt = '0;
    if (scratch == '0) begin
      next_cnt = (still_cnt >= SETTLE) ? SETTLE : still_cnt + 8'd1;
    end
  end

  assign dbg_state = state;

  // Scan FSM with registered outputs; clear outranks every other update.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      scratch     <= '0;
      primed      <= 1'b0;
      hw_sig      <= 1'b0;
      moving_mask <= '1;
      still_cnt   <= '0;
      overrun     <= 1'b0;
      for (int i = 0; i < NBALLS; i++) prev_pos[i] <= '0;
    end else if (clear) begin
      state       <= IDLE;
      idx         <= '0;
      scratch     <= '0;
      primed      <= 1'b0;
      hw_sig      <= 1'b0;
      moving_mask <= '1;
      still_cnt   <= '0;
      overrun     <= 1'b0;
    end else begin
      if (frame_tick && (state != IDLE)) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (frame_tick) begin
            state   <= SCAN;
            idx     <= '0;
            scratch <= '0;
          end
        end
        SCAN: begin
          scratch[idx]  <= moved;
          prev_pos[idx] <= cur;
          if (idx == LAST_IDX) state <= EVAL;
          else idx <= idx + 1'b1;
        end
        EVAL: begin
          moving_mask <= scratch;
          primed      <= 1'b1;
          still_cnt   <= next_cnt;
          hw_sig      <= (next_cnt == SETTLE);
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion_monitor.sv
// Bench for ball_motion_monitor: directed scenarios followed by random
// frames, each checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_ball_motion_monitor;
  import billiards_pkg::*;

  localparam int NB     = 16;
  localparam int SETTLE = 8;
  localparam int TH     = 1;
  localparam int EXP_W  = 26;

  logic              clk_clk = 1'b0;
  logic              reset_reset_n;
  logic              frame_tick;
  logic              clear;
  logic [NB*20-1:0]  ball_pos;
  logic              hw_sig;
  logic [NB-1:0]     moving_mask;
  logic [7:0]        still_cnt;
  logic              overrun;
  mon_state_t        dbg_state;

  ball_motion_monitor dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .frame_tick    (frame_tick),
    .clear         (clear),
    .ball_pos      (ball_pos),
    .hw_sig        (hw_sig),
    .moving_mask   (moving_mask),
    .still_cnt     (still_cnt),
    .overrun       (overrun),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk_clk = ~clk_clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];

  // Reference model: positions in plain integers, one step per frame.
  int cur_x [NB];
  int cur_y [NB];
  int prev_x [NB];
  int prev_y [NB];
  bit m_primed;
  int m_cnt;
  bit m_ovr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [NB*20-1:0] pack_pos();
    logic [NB*20-1:0] p;
    p = '0;
    for (int i = 0; i < NB; i++) p[20*i +: 20] = {10'(cur_x[i]), 10'(cur_y[i])};
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      prev_x[i] = 0;
      prev_y[i] = 0;
    end
    m_primed = 0;
    m_cnt    = 0;
    m_ovr    = 0;
  endtask

  task automatic model_clear();
    m_primed = 0;
    m_cnt    = 0;
    m_ovr    = 0;
  endtask

  // One complete frame: which balls moved, then the still-frame bookkeeping.
  task automatic model_frame();
    logic [NB-1:0] mask;
    logic          hw;
    int dx, dy;
    mask = '0;
    for (int i = 0; i < NB; i++) begin
      dx = cur_x[i] - prev_x[i];
      dy = cur_y[i] - prev_y[i];
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      if (cur_x[i] != 1023 && (!m_primed || dx > TH || dy > TH)) mask[i] = 1'b1;
      prev_x[i] = cur_x[i];
      prev_y[i] = cur_y[i];
    end
    m_primed = 1;
    if (mask == '0) m_cnt = (m_cnt + 1 > SETTLE) ? SETTLE : m_cnt + 1;
    else m_cnt = 0;
    hw = (m_cnt == SETTLE);
    exp_q.push_back({mask, 8'(m_cnt), hw, m_ovr});
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick_only();
    ball_pos   = pack_pos();
    frame_tick = 1'b1;
    @(posedge clk_clk);
    #1 frame_tick = 1'b0;
  endtask

  task automatic run_frame(input bit with_overrun);
    if (with_overrun) m_ovr = 1;
    model_frame();
    tick_only();
    if (with_overrun) begin
      repeat (4) @(posedge clk_clk);
      #1 frame_tick = 1'b1;
      @(posedge clk_clk);
      #1 frame_tick = 1'b0;
    end
    repeat (18) @(posedge clk_clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk_clk);
    #1 clear = 1'b0;
    model_clear();
  endtask

  // ---------------- monitor ----------------
  // The cycle after the FSM leaves EVAL is when fresh outputs are visible.
  bit was_eval = 0;
  always @(negedge clk_clk) begin
    logic [EXP_W-1:0] e;
    if (!reset_reset_n) begin
      was_eval = 0;
    end else begin
      if (was_eval) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_eval actual=output_update required=none");
        end else begin
          e = exp_q.pop_front();
          check("frame_mask",    32'(moving_mask), 32'(e[25:10]));
          check("frame_cnt",     32'(still_cnt),   32'(e[9:2]));
          check("frame_hw_sig",  32'(hw_sig),      32'(e[1]));
          check("frame_overrun", 32'(overrun),     32'(e[0]));
        end
      end
      was_eval = (dbg_state == EVAL);
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timed out");
  end

  // ---------------- stimulus ----------------
  initial begin
    int r, v;
    reset_reset_n = 1'b0;
    frame_tick    = 1'b0;
    clear         = 1'b0;
    for (int i = 0; i < NB; i++) begin
      cur_x[i] = 100;
      cur_y[i] = 100;
    end
    ball_pos = pack_pos();
    model_reset();

    repeat (3) @(posedge clk_clk);
    #1;
    check("rst_mask",    32'(moving_mask), 32'hFFFF);
    check("rst_cnt",     32'(still_cnt),   32'd0);
    check("rst_hw_sig",  32'(hw_sig),      32'd0);
    check("rst_overrun", 32'(overrun),     32'd0);
    check("rst_state",   32'(dbg_state),   32'(IDLE));
    reset_reset_n = 1'b1;
    @(posedge clk_clk);
    #1;

    // Prime: three frames with all balls parked at (100,100).
    repeat (3) run_frame(0);

    // Settle: the sixth of these frames brings the count to SETTLE.
    for (int k = 0; k < 10; k++) begin
      if (k == 5) begin
        model_frame();
        tick_only();
        repeat (16) @(posedge clk_clk);
        #1 check("settle_lat_pre", 32'(hw_sig), 32'd0);
        @(posedge clk_clk);
        #1 check("settle_lat_18", 32'(hw_sig), 32'd1);
        repeat (2) @(posedge clk_clk);
        #1;
      end else begin
        run_frame(0);
      end
    end

    // Threshold: delta of 1 is still, delta of 2 is movement.
    cur_x[5] = 101;
    run_frame(0);
    cur_x[5] = 103;
    run_frame(0);

    // Pocket: ball 9 placed, held, then dropped into a pocket.
    cur_x[9] = 300;
    cur_y[9] = 200;
    run_frame(0);
    run_frame(0);
    cur_x[9] = 1023;
    cur_y[9] = 0;
    run_frame(0);

    // Overrun: a second tick mid-scan is dropped but flagged.
    run_frame(1);
    check("overrun_sticky", 32'(overrun), 32'd1);
    do_clear();
    check("clear_overrun", 32'(overrun),     32'd0);
    check("clear_cnt",     32'(still_cnt),   32'd0);
    check("clear_mask",    32'(moving_mask), 32'hFFFF);
    check("clear_hw_sig",  32'(hw_sig),      32'd0);
    run_frame(0);
    run_frame(0);

    // Asynchronous reset in the middle of a scan, off the clock edge.
    cur_x[9] = 300;
    cur_y[9] = 200;
    tick_only();
    repeat (7) @(posedge clk_clk);
    #2 reset_reset_n = 1'b0;
    #2;
    check("amid_mask",    32'(moving_mask), 32'hFFFF);
    check("amid_cnt",     32'(still_cnt),   32'd0);
    check("amid_hw_sig",  32'(hw_sig),      32'd0);
    check("amid_overrun", 32'(overrun),     32'd0);
    check("amid_state",   32'(dbg_state),   32'(IDLE));
    #3 reset_reset_n = 1'b1;
    model_reset();
    @(posedge clk_clk);
    #1;
    run_frame(0);
    run_frame(0);

    // Random frames: mixtures of still, jitter, jumps, pockets and overruns.
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 9) == 0) do_clear();
      if ($urandom_range(0, 2) != 0) begin
        for (int i = 0; i < NB; i++) begin
          r = int'($urandom_range(0, 9));
          if (r >= 5 && r <= 6 && cur_x[i] != 1023) begin
            v = cur_x[i] + int'($urandom_range(0, 2)) - 1;
            cur_x[i] = (v < 0) ? 0 : (v > 1000) ? 1000 : v;
            v = cur_y[i] + int'($urandom_range(0, 2)) - 1;
            cur_y[i] = (v < 0) ? 0 : (v > 1023) ? 1023 : v;
          end else if (r >= 7 && r <= 8) begin
            cur_x[i] = int'($urandom_range(0, 1000));
            cur_y[i] = int'($urandom_range(0, 1023));
          end else if (r == 9) begin
            cur_x[i] = 1023;
            cur_y[i] = int'($urandom_range(0, 1023));
          end
        end
      end
      run_frame($urandom_range(0, 5) == 0);
    end

    // Every expected frame must have been presented by the DUT.
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk_clk);
    check("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
